// File: rtl/bcd_9comp_decoder.sv
// bcd_9comp_decoder: digit-serial 9's-complement BCD decoder, LSD first; optional 10's complement via TENS_COMP_EN
module bcd_9comp_decoder #(
    parameter int DIGITS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4*DIGITS-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*DIGITS-1:0] out_bcd,
    output logic              out_err,
    output logic              busy
);
    localparam int W = 4 * DIGITS;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [3:0] LAST = 4'(DIGITS - 1);

    logic [1:0]   state;
    logic [W-1:0] sr;
    logic [3:0]   cnt;
    logic [3:0]   c;
    logic [3:0]   d;
    logic         bad;

    assign c   = sr[3:0];
    assign bad = c > 4'd9;

`ifdef TENS_COMP_EN
    logic       carry;
    logic       carry_nxt;
    logic [3:0] s;

    // Decode the current digit with the running +1 carry; an illegal code kills the carry
    always_comb begin
        s         = 4'd9 - c + {3'b000, carry};
        d         = bad ? 4'hF : (s == 4'd10 ? 4'd0 : s);
        carry_nxt = !bad && s == 4'd10;
    end

    // Carry starts at 1 for each word and ripples one digit per cycle; the MSD carry-out is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            carry <= 1'b0;
        else if (state == IDLE && in_valid)
            carry <= 1'b1;
        else if (state == CONV)
            carry <= carry_nxt;
    end
`else
    // Decode the current digit; an illegal code becomes F
    always_comb begin
        d = bad ? 4'hF : 4'd9 - c;
    end
`endif

    // Control FSM, input shift register and result shift-in from the top
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sr      <= '0;
            cnt     <= '0;
            out_bcd <= '0;
            out_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sr      <= in_code;
                    cnt     <= '0;
                    out_err <= 1'b0;
                    state   <= CONV;
                end
                CONV: begin
                    sr      <= sr >> 4;
                    out_bcd <= (out_bcd >> 4) | (W'(d) << (W - 4));
                    out_err <= out_err | bad;
                    cnt     <= cnt + 4'd1;
                    if (cnt == LAST) state <= DONE;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
endmodule
